mem_arbiter: RTL and testbench

Shares the single block-RAM port of the multicycle core between instruction fetch and load/store accesses. A four-state FSM serves one transaction at a time and grants by round-robin on contention. It holds each transaction's address, write data and write enable for the full memory latency, and returns a one-cycle acknowledge. It sits between the controller/datapath and the memory, in place of a direct core-to-RAM connection.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-RAM port between instruction fetch and
// load/store traffic. One transaction at a time, round-robin on contention,
// address/data/we held for the whole memory latency, one-cycle acknowledge.
module mem_arbiter #(
  parameter int AW   = 17,
  parameter int DW   = 32,
  parameter int RLAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Port identifiers used for the winner latch and last_grant.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          win_d;

  // Next-state, arbitration, latch and read-capture logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    win_d     = GNT_I;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // Data wins if it is alone, or on contention when fetch went last.
          win_d   = d_req && (!i_req || (last_q == GNT_I));
          gnt_d   = win_d;
          last_d  = win_d;
          we_d    = win_d && d_we;
          addr_d  = win_d ? d_addr : i_addr;
          if (win_d) begin
            wdata_d = d_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = 4'(RLAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The counter hits zero at this edge: memory data is valid now.
        if (cnt_q == 4'd1) begin
          if (gnt_q == GNT_D) begin
            d_rdata_d = m_rdata;
          end else begin
            i_rdata_d = m_rdata;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= GNT_I;
      gnt_q     <= GNT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs are pure decodes of registered state, never of the requests.
  always_comb begin
    m_en    = (state_q == ISSUE);
    m_we    = (state_q == ISSUE) && we_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    i_ack   = (state_q == ACK) && (gnt_q == GNT_I);
    d_ack   = (state_q == ACK) && (gnt_q == GNT_D);
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset state, single reads/writes,
// round-robin contention, reset abort, and RLAT=1/8 latency builds.
module tb_mem_arbiter;
  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int RLAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, i_ack, d_req, d_we, d_ack, m_en, m_we;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

  // Signals of the RLAT=1 and RLAT=8 instances (fetch port only).
  logic          z_req, z_we;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_wdata;
  logic          x1_ireq, x1_iack, x1_dack, x1_men, x1_mwe;
  logic [AW-1:0] x1_maddr;
  logic [DW-1:0] x1_irdata, x1_drdata, x1_mwdata, x1_mrdata;
  logic          x8_ireq, x8_iack, x8_dack, x8_men, x8_mwe;
  logic [AW-1:0] x8_maddr;
  logic [DW-1:0] x8_irdata, x8_drdata, x8_mwdata, x8_mrdata;

  mem_arbiter #(.AW(AW), .DW(DW), .RLAT(RLAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RLAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(x1_ireq), .i_addr(z_addr), .i_rdata(x1_irdata), .i_ack(x1_iack),
    .d_req(z_req), .d_we(z_we), .d_addr(z_addr), .d_wdata(z_wdata),
    .d_rdata(x1_drdata), .d_ack(x1_dack),
    .m_en(x1_men), .m_we(x1_mwe), .m_addr(x1_maddr), .m_wdata(x1_mwdata),
    .m_rdata(x1_mrdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RLAT(8)) dut8 (
    .clk(clk), .rst(rst),
    .i_req(x8_ireq), .i_addr(z_addr), .i_rdata(x8_irdata), .i_ack(x8_iack),
    .d_req(z_req), .d_we(z_we), .d_addr(z_addr), .d_wdata(z_wdata),
    .d_rdata(x8_drdata), .d_ack(x8_dack),
    .m_en(x8_men), .m_we(x8_mwe), .m_addr(x8_maddr), .m_wdata(x8_mwdata),
    .m_rdata(x8_mrdata)
  );

  // Memory model for the main instance: fixed contents plus a small
  // written-word store; read data appears only in cycle m_en+RLAT.
  logic [31:0] wmem [0:31];
  logic [31:0] wvld;
  logic        mem_clr;
  logic [31:0] rd_pipe [0:7];

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    if (wvld[a[4:0]]) return wmem[a[4:0]];
    case (a)
      17'h00010: return 32'hDEADBEEF;
      17'h00020: return 32'hCAFEF00D;
      default:   return {15'h0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_clr) wvld <= '0;
    else if (m_en && m_we) begin
      wmem[m_addr[4:0]] <= m_wdata;
      wvld[m_addr[4:0]] <= 1'b1;
    end
    rd_pipe[0] <= (m_en && !m_we) ? mem_rd(m_addr) : 32'h0;
    for (int k = 1; k < 8; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign m_rdata = rd_pipe[RLAT-1];

  // Latency-only memories for the RLAT=1 and RLAT=8 instances.
  logic [7:0] sh1, sh8;
  always @(posedge clk) begin
    sh1 <= {sh1[6:0], x1_men};
    sh8 <= {sh8[6:0], x8_men};
  end
  assign x1_mrdata = sh1[0] ? 32'h11110001 : 32'h0;
  assign x8_mrdata = sh8[7] ? 32'h88880008 : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance; req is raised in the current
  // (IDLE) cycle, which is cycle 0, and dropped the cycle after the ack.
  task automatic do_txn(input bit is_d, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int exp_ack,
                        input logic [DW-1:0] exp_rd, input string tag);
    int ack_c, en_n;
    logic other;
    logic [DW-1:0] rdv, wd1;
    logic [AW-1:0] a1;
    logic we1;
    ack_c = -1; en_n = 0; other = 1'b0; rdv = '0; wd1 = '0; a1 = '0; we1 = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 1; c <= 20 && ack_c < 0; c++) begin
      tick();
      if (m_en) en_n++;
      if (c == 1) begin
        a1 = m_addr; we1 = m_we; wd1 = m_wdata;
      end
      if (is_d ? d_ack : i_ack) begin
        ack_c = c;
        rdv = is_d ? d_rdata : i_rdata;
      end
      if (is_d ? i_ack : d_ack) other = 1'b1;
    end
    check({tag, " ack_cycle"}, 32'(ack_c), 32'(exp_ack));
    check({tag, " m_en_pulses"}, 32'(en_n), 32'd1);
    check({tag, " m_addr"}, 32'(a1), 32'(addr));
    check({tag, " m_we"}, 32'(we1), 32'(we));
    check({tag, " other_ack"}, 32'(other), 32'd0);
    if (we) check({tag, " m_wdata"}, wd1, wdata);
    else    check({tag, " rdata"}, rdv, exp_rd);
    tick();
    check({tag, " ack_width"}, 32'(is_d ? d_ack : i_ack), 32'd0);
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  int  ev_cyc [0:3];
  logic ev_prt [0:3];
  int  nev, ack1, ack8;
  logic pi, pd, ovl, wide, stray;
  logic [DW-1:0] r1, r8;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0;
    x1_ireq = 1'b0; x8_ireq = 1'b0;
    repeat (10) tick();
    rst = 1'b0; mem_clr = 1'b0;

    // Idle after reset: nothing moves.
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle m_en", 32'(m_en), 32'd0);
    end
    check("rst i_ack", 32'(i_ack), 32'd0);
    check("rst d_ack", 32'(d_ack), 32'd0);
    check("rst m_we", 32'(m_we), 32'd0);
    check("rst m_addr", 32'(m_addr), 32'd0);
    check("rst m_wdata", m_wdata, 32'd0);
    check("rst i_rdata", i_rdata, 32'd0);
    check("rst d_rdata", d_rdata, 32'd0);

    // Single fetch, store, load.
    do_txn(1'b0, 1'b0, 17'h00010, 32'h0, 4, 32'hDEADBEEF, "fetch10");
    do_txn(1'b1, 1'b1, 17'h1FFFF, 32'h12345678, 2, 32'h0, "store");
    check("store keeps d_rdata", d_rdata, 32'h0);
    do_txn(1'b1, 1'b0, 17'h1FFFF, 32'h0, 4, 32'h12345678, "load");
    check("load keeps i_rdata", i_rdata, 32'hDEADBEEF);

    // Contention from reset: both held continuously.
    rst = 1'b1;
    i_req = 1'b1; i_addr = 17'h00010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 17'h1FFFF;
    tick(); tick();
    rst = 1'b0;
    nev = 0; pi = 1'b0; pd = 1'b0; ovl = 1'b0; wide = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (i_ack && d_ack) ovl = 1'b1;
      if ((i_ack && pi) || (d_ack && pd)) wide = 1'b1;
      if ((i_ack || d_ack) && nev < 4) begin
        ev_cyc[nev] = c; ev_prt[nev] = d_ack; nev++;
      end
      pi = i_ack; pd = d_ack;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("rr events", 32'(nev), 32'd4);
    check("rr overlap", 32'(ovl), 32'd0);
    check("rr ack_width", 32'(wide), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < nev) begin
        check($sformatf("rr port%0d", k), 32'(ev_prt[k]), 32'((k % 2) == 0));
        check($sformatf("rr cycle%0d", k), 32'(ev_cyc[k]), 32'(4 + 5 * k));
      end
    end
    check("rr d_rdata", d_rdata, 32'h12345678);
    check("rr i_rdata", i_rdata, 32'hDEADBEEF);
    tick(); tick();

    // Reset during WAIT of a fetch.
    i_req = 1'b1; i_addr = 17'h00020;
    tick();
    check("abort issue m_en", 32'(m_en), 32'd1);
    tick();
    rst = 1'b1; i_req = 1'b0;
    tick();
    rst = 1'b0;
    check("abort m_en", 32'(m_en), 32'd0);
    check("abort m_addr", 32'(m_addr), 32'd0);
    check("abort i_rdata", i_rdata, 32'd0);
    stray = i_ack;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (i_ack || d_ack) stray = 1'b1;
    end
    check("abort no ack", 32'(stray), 32'd0);
    do_txn(1'b0, 1'b0, 17'h00020, 32'h0, 4, 32'hCAFEF00D, "refetch");

    // RLAT=1 and RLAT=8 builds.
    x1_ireq = 1'b1; x8_ireq = 1'b1;
    ack1 = -1; ack8 = -1; r1 = '0; r8 = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (x1_iack && ack1 < 0) begin ack1 = c; r1 = x1_irdata; x1_ireq = 1'b0; end
      if (x8_iack && ack8 < 0) begin ack8 = c; r8 = x8_irdata; x8_ireq = 1'b0; end
    end
    x1_ireq = 1'b0; x8_ireq = 1'b0;
    check("rlat1 ack_cycle", 32'(ack1), 32'd3);
    check("rlat1 rdata", r1, 32'h11110001);
    check("rlat8 ack_cycle", 32'(ack8), 32'd10);
    check("rlat8 rdata", r8, 32'h88880008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
